// File: rtl/matrix_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// matrix_cmd_sequencer
//
// Decodes host command codes and sequences the filter, multi-round inventory,
// ReqRN + access and purge operations. Adds a per-state watchdog, a
// completion pulse with a result code, and a stop/abort from any busy state.
//
// Ports:
//   Clk, Reset            clock, asynchronous active-high reset
//   r_ExecHostCmd         host command code (0 = no command)
//   r_NumRounds           inventory rounds per command (0 = run until stop)
//   r_TmoLimit            watchdog limit in cycles (0 = watchdog disabled)
//   s_RstHostCmd          registered request to clear the host command register
//   SeqState              one-hot state {WAIT,ACCESS,REQRN,INV,FILTER,IDLE}
//   s_Busy                high whenever SeqState is not IDLE
//   s_Done, s_Status      one-cycle completion pulse; status 0 none, 1 ok,
//                         2 aborted, 3 timeout (held until the next s_Done)
//   h_Start*/h_End*       engine start pulses / engine completion inputs
//   h_Purge               one-cycle tag-buffer flush pulse
//   s_RoundCnt            completed rounds of the current inventory
//
// Engine handshake: every h_Start* is a single-cycle request raised on the
// first cycle of the state that owns that engine. The matching h_End* is a
// single-cycle completion that is honoured only while in that state; an End
// seen in any other state is ignored.
// -----------------------------------------------------------------------------
module matrix_cmd_sequencer #(
    parameter int CMD_W      = 4,
    parameter int ROUND_W    = 8,
    parameter int TMO_W      = 16,
    parameter int CMD_FILTER = 1,
    parameter int CMD_INV    = 2,
    parameter int CMD_ACCESS = 3,
    parameter int CMD_PURGE  = 4,
    parameter int CMD_STOP   = 5,
    parameter int Tp         = 1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [CMD_W-1:0]   r_ExecHostCmd,
    input  logic [ROUND_W-1:0] r_NumRounds,
    input  logic [TMO_W-1:0]   r_TmoLimit,
    output logic               s_RstHostCmd,
    output logic [5:0]         SeqState,
    output logic               s_Busy,
    output logic               s_Done,
    output logic [1:0]         s_Status,
    output logic               h_StartFilter,
    input  logic               h_EndFilter,
    output logic               h_StartHInvRound,
    input  logic               h_EndHinvRound,
    output logic               h_StartReqRn,
    input  logic               h_EndReqRn,
    output logic               h_StartAccess,
    input  logic               h_EndAccess,
    output logic               h_Purge,
    output logic [ROUND_W-1:0] s_RoundCnt
);

    // Tp is carried over from the predecessor's interface; registers here are
    // zero-delay, so it only has to be a sane value.
    if (Tp < 0) begin : gTpNegative
    end

    typedef enum logic [5:0] {
        IDLE   = 6'b000001,
        FILTER = 6'b000010,
        INV    = 6'b000100,
        REQRN  = 6'b001000,
        ACCESS = 6'b010000,
        WAIT   = 6'b100000
    } seqState_e;

    localparam logic [CMD_W-1:0] CmdFilter = CMD_W'(CMD_FILTER);
    localparam logic [CMD_W-1:0] CmdInv    = CMD_W'(CMD_INV);
    localparam logic [CMD_W-1:0] CmdAccess = CMD_W'(CMD_ACCESS);
    localparam logic [CMD_W-1:0] CmdPurge  = CMD_W'(CMD_PURGE);
    localparam logic [CMD_W-1:0] CmdStop   = CMD_W'(CMD_STOP);

    localparam logic [1:0] StOk      = 2'd1;
    localparam logic [1:0] StAbort   = 2'd2;
    localparam logic [1:0] StTimeout = 2'd3;

    seqState_e          state, nextState;
    logic [TMO_W-1:0]   tmoCnt;
    logic [ROUND_W-1:0] roundInc, roundCntNext;
    logic [1:0]         statusNext;
    logic               doneNext, purgeNext;
    logic               cmdFilter, cmdInv, cmdAccess, cmdPurge, cmdStop, cmdKnown;
    logic               counting, tmoHit;

    assign cmdFilter = (r_ExecHostCmd == CmdFilter);
    assign cmdInv    = (r_ExecHostCmd == CmdInv);
    assign cmdAccess = (r_ExecHostCmd == CmdAccess);
    assign cmdPurge  = (r_ExecHostCmd == CmdPurge);
    assign cmdStop   = (r_ExecHostCmd == CmdStop);
    assign cmdKnown  = cmdFilter | cmdInv | cmdAccess | cmdPurge | cmdStop;

    assign roundInc = s_RoundCnt + ROUND_W'(1);

    // The counter holds the number of cycles already spent in the state, so
    // the limit-th cycle is the one where it equals limit-1.
    assign counting = (state == FILTER) || (state == INV) ||
                      (state == REQRN)  || (state == ACCESS);
    assign tmoHit   = (r_TmoLimit != '0) && (tmoCnt == r_TmoLimit - TMO_W'(1));

    assign SeqState = state;
    assign s_Busy   = (state != IDLE);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState    = state;
        doneNext     = 1'b0;
        statusNext   = s_Status;
        roundCntNext = s_RoundCnt;
        purgeNext    = 1'b0;

        // Purge completes the cycle after its flush pulse.
        if (h_Purge) begin
            doneNext   = 1'b1;
            statusNext = StOk;
        end

        case (state)
            IDLE: begin
                if (cmdFilter) begin
                    nextState = FILTER;
                end else if (cmdInv) begin
                    nextState    = INV;
                    roundCntNext = '0;
                end else if (cmdAccess) begin
                    nextState = REQRN;
                end else if (cmdPurge) begin
                    purgeNext = 1'b1;
                end
            end
            FILTER: begin
                if (h_EndFilter) begin
                    nextState  = IDLE;
                    doneNext   = 1'b1;
                    statusNext = StOk;
                end
            end
            INV: begin
                if (h_EndHinvRound) begin
                    roundCntNext = roundInc;
                    if ((r_NumRounds != '0) && (roundInc == r_NumRounds)) begin
                        nextState  = IDLE;
                        doneNext   = 1'b1;
                        statusNext = StOk;
                    end else begin
                        nextState = WAIT;
                    end
                end
            end
            REQRN: begin
                if (h_EndReqRn) begin
                    nextState = ACCESS;
                end
            end
            ACCESS: begin
                if (h_EndAccess) begin
                    nextState  = IDLE;
                    doneNext   = 1'b1;
                    statusNext = StOk;
                end
            end
            WAIT: begin
                nextState = INV;
            end
            default: begin
                nextState = IDLE;
            end
        endcase

        // An End that already moved the state wins over a coincident timeout.
        if (counting && tmoHit && (nextState == state)) begin
            nextState  = IDLE;
            doneNext   = 1'b1;
            statusNext = StTimeout;
        end

        // Stop overrides everything; a coincident round End is dropped.
        if ((state != IDLE) && cmdStop) begin
            nextState    = IDLE;
            doneNext     = 1'b1;
            statusNext   = StAbort;
            roundCntNext = s_RoundCnt;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            tmoCnt           <= '0;
            s_RstHostCmd     <= 1'b0;
            s_Done           <= 1'b0;
            s_Status         <= 2'd0;
            s_RoundCnt       <= '0;
            h_Purge          <= 1'b0;
            h_StartFilter    <= 1'b0;
            h_StartHInvRound <= 1'b0;
            h_StartReqRn     <= 1'b0;
            h_StartAccess    <= 1'b0;
        end else begin
            s_RstHostCmd     <= cmdKnown;
            s_Done           <= doneNext;
            s_Status         <= statusNext;
            s_RoundCnt       <= roundCntNext;
            h_Purge          <= purgeNext;
            h_StartFilter    <= (nextState == FILTER) && (state != FILTER);
            h_StartHInvRound <= (nextState == INV)    && (state != INV);
            h_StartReqRn     <= (nextState == REQRN)  && (state != REQRN);
            h_StartAccess    <= (nextState == ACCESS) && (state != ACCESS);
            if (nextState != state) begin
                tmoCnt <= '0;
            end else if (counting) begin
                tmoCnt <= tmoCnt + TMO_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_matrix_cmd_sequencer.sv
module tb_matrix_cmd_sequencer;

    localparam logic [3:0] CMD_FILTER = 4'd1;
    localparam logic [3:0] CMD_INV    = 4'd2;
    localparam logic [3:0] CMD_ACCESS = 4'd3;
    localparam logic [3:0] CMD_PURGE  = 4'd4;
    localparam logic [3:0] CMD_STOP   = 4'd5;

    localparam logic [5:0] S_IDLE   = 6'b000001;
    localparam logic [5:0] S_FILTER = 6'b000010;
    localparam logic [5:0] S_INV    = 6'b000100;
    localparam logic [5:0] S_REQRN  = 6'b001000;
    localparam logic [5:0] S_ACCESS = 6'b010000;
    localparam logic [5:0] S_WAIT   = 6'b100000;

    logic        Clk;
    logic        Reset;
    logic [3:0]  r_ExecHostCmd;
    logic [7:0]  r_NumRounds;
    logic [15:0] r_TmoLimit;
    logic        s_RstHostCmd;
    logic [5:0]  SeqState;
    logic        s_Busy;
    logic        s_Done;
    logic [1:0]  s_Status;
    logic        h_StartFilter, h_EndFilter;
    logic        h_StartHInvRound, h_EndHinvRound;
    logic        h_StartReqRn, h_EndReqRn;
    logic        h_StartAccess, h_EndAccess;
    logic        h_Purge;
    logic [7:0]  s_RoundCnt;

    matrix_cmd_sequencer dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .r_ExecHostCmd    (r_ExecHostCmd),
        .r_NumRounds      (r_NumRounds),
        .r_TmoLimit       (r_TmoLimit),
        .s_RstHostCmd     (s_RstHostCmd),
        .SeqState         (SeqState),
        .s_Busy           (s_Busy),
        .s_Done           (s_Done),
        .s_Status         (s_Status),
        .h_StartFilter    (h_StartFilter),
        .h_EndFilter      (h_EndFilter),
        .h_StartHInvRound (h_StartHInvRound),
        .h_EndHinvRound   (h_EndHinvRound),
        .h_StartReqRn     (h_StartReqRn),
        .h_EndReqRn       (h_EndReqRn),
        .h_StartAccess    (h_StartAccess),
        .h_EndAccess      (h_EndAccess),
        .h_Purge          (h_Purge),
        .s_RoundCnt       (s_RoundCnt)
    );

    // ---------------- clock ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL global_time_limit: simulation did not reach its end");
        $fatal(1, "time limit");
    end

    logic [17:0] outs;
    assign outs = {s_RstHostCmd, s_Busy, s_Done, s_Status, h_StartFilter, h_StartHInvRound,
                   h_StartReqRn, h_StartAccess, h_Purge, s_RoundCnt};

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    // observed activity during one transaction
    int nFilt, nInv, nReq, nAcc, nPurge, nRst, nDone, nCycFilt, busyBad;
    logic [1:0] doneStatus;
    logic [5:0] path_q[$];

    // engine responders: latency in cycles after start (-1 = never answers)
    int fLat, iLat, rLat, aLat;
    int fCd, iCd, rCd, aCd;
    int stopAt;

    // scoreboard expectations
    logic [5:0] exp_q[$];
    int eFilt, eInv, eReq, eAcc, ePurge, eRst, eFiltCyc, eCnt;
    logic [1:0] eStatus;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int next_cd(input int cd, input logic start, input int lat);
        if (start) return lat;
        if (cd > 0) return cd - 1;
        return -1;
    endfunction

    // ---------------- driver ----------------
    // One clock: sample outputs #1 after the edge, then drive the inputs for
    // the cycle that has just begun.
    task automatic step();
        @(posedge Clk);
        #1;
        if (h_StartFilter)    nFilt++;
        if (h_StartHInvRound) nInv++;
        if (h_StartReqRn)     nReq++;
        if (h_StartAccess)    nAcc++;
        if (h_Purge)          nPurge++;
        if (s_RstHostCmd)     nRst++;
        if (SeqState == S_FILTER) nCycFilt++;
        if ((s_Busy !== (SeqState != S_IDLE)) || !$onehot(SeqState)) busyBad++;
        if (s_Done) begin
            nDone++;
            doneStatus = s_Status;
        end
        if (SeqState != path_q[path_q.size() - 1]) path_q.push_back(SeqState);
        fCd = next_cd(fCd, h_StartFilter, fLat);    h_EndFilter    = (fCd == 0);
        iCd = next_cd(iCd, h_StartHInvRound, iLat); h_EndHinvRound = (iCd == 0);
        rCd = next_cd(rCd, h_StartReqRn, rLat);     h_EndReqRn     = (rCd == 0);
        aCd = next_cd(aCd, h_StartAccess, aLat);    h_EndAccess    = (aCd == 0);
        if ((stopAt != 0) && h_StartHInvRound && (nInv == stopAt)) r_ExecHostCmd = CMD_STOP;
        else r_ExecHostCmd = 4'd0;
    endtask

    task automatic clear();
        nFilt = 0; nInv = 0; nReq = 0; nAcc = 0; nPurge = 0; nRst = 0; nDone = 0;
        nCycFilt = 0; busyBad = 0; doneStatus = 2'd0;
        fCd = -1; iCd = -1; rCd = -1; aCd = -1;
        h_EndFilter = 1'b0; h_EndHinvRound = 1'b0; h_EndReqRn = 1'b0; h_EndAccess = 1'b0;
        path_q.delete();
        path_q.push_back(S_IDLE);
    endtask

    // command is present for exactly one cycle
    task automatic issue(input logic [3:0] cmd);
        r_ExecHostCmd = cmd;
        step();
    endtask

    // ---------------- reference model ----------------
    task automatic model_base();
        exp_q.delete();
        exp_q.push_back(S_IDLE);
        eFilt = 0; eInv = 0; eReq = 0; eAcc = 0; ePurge = 0; eRst = 1; eFiltCyc = 0;
        eStatus = 2'd0;
    endtask

    function automatic logic times_out(input int lat, input int tmo);
        return (tmo != 0) && ((lat < 0) || (lat + 1 > tmo));
    endfunction

    task automatic model_filter(input int lat, input int tmo);
        model_base();
        eFilt = 1;
        exp_q.push_back(S_FILTER);
        if (times_out(lat, tmo)) begin
            eStatus = 2'd3; eFiltCyc = tmo;
        end else begin
            eStatus = 2'd1; eFiltCyc = lat + 1;
        end
        exp_q.push_back(S_IDLE);
    endtask

    task automatic model_access(input int l1, input int l2, input int tmo);
        model_base();
        eReq = 1;
        exp_q.push_back(S_REQRN);
        if (times_out(l1, tmo)) begin
            eStatus = 2'd3;
        end else begin
            eAcc = 1;
            exp_q.push_back(S_ACCESS);
            eStatus = times_out(l2, tmo) ? 2'd3 : 2'd1;
        end
        exp_q.push_back(S_IDLE);
    endtask

    // rounds run one after another separated by one WAIT cycle; stop is
    // raised on the first cycle of round stopRound
    task automatic model_inv(input int n, input int lat, input int tmo, input int stopRound);
        int completed;
        model_base();
        completed = 0;
        exp_q.push_back(S_INV);
        for (int r = 1; r <= 300; r++) begin
            eInv++;
            if (stopRound == r) begin
                eStatus = 2'd2;
                break;
            end
            if (times_out(lat, tmo)) begin
                eStatus = 2'd3;
                break;
            end
            completed++;
            if ((n != 0) && (completed == n)) begin
                eStatus = 2'd1;
                break;
            end
            exp_q.push_back(S_WAIT);
            exp_q.push_back(S_INV);
        end
        exp_q.push_back(S_IDLE);
        eCnt = completed % 256;
        if (eStatus == 2'd2) eRst = 2;
    endtask

    // ---------------- scoreboard ----------------
    task automatic finish_txn(input string tag);
        int n;
        n = 0;
        while ((nDone == 0) && (n < 2000)) begin
            step();
            n++;
        end
        check({tag, "_done_seen"}, 32'(nDone != 0), 32'd1);
        repeat (3) step();
        check({tag, "_done_count"}, nDone, 1);
        check({tag, "_done_status"}, doneStatus, eStatus);
        check({tag, "_status_held"}, s_Status, eStatus);
        check({tag, "_start_filter"}, nFilt, eFilt);
        check({tag, "_start_inv"}, nInv, eInv);
        check({tag, "_start_reqrn"}, nReq, eReq);
        check({tag, "_start_access"}, nAcc, eAcc);
        check({tag, "_purge"}, nPurge, ePurge);
        check({tag, "_rst_host"}, nRst, eRst);
        check({tag, "_filter_cycles"}, nCycFilt, eFiltCyc);
        check({tag, "_round_cnt"}, s_RoundCnt, eCnt);
        check({tag, "_busy_onehot"}, busyBad, 0);
        check({tag, "_path_len"}, path_q.size(), exp_q.size());
        for (int i = 0; (i < exp_q.size()) && (i < path_q.size()); i++)
            check($sformatf("%s_path%0d", tag, i), path_q[i], exp_q[i]);
    endtask

    task automatic run_filter(input string tag, input int lat, input int tmo);
        r_TmoLimit = tmo[15:0];
        fLat = lat;
        model_filter(lat, tmo);
        clear();
        issue(CMD_FILTER);
        finish_txn(tag);
    endtask

    task automatic run_access(input string tag, input int l1, input int l2, input int tmo);
        r_TmoLimit = tmo[15:0];
        rLat = l1;
        aLat = l2;
        model_access(l1, l2, tmo);
        clear();
        issue(CMD_ACCESS);
        finish_txn(tag);
    endtask

    task automatic run_inv(input string tag, input int n, input int lat, input int tmo,
                           input int stopRound);
        r_NumRounds = n[7:0];
        r_TmoLimit  = tmo[15:0];
        iLat   = lat;
        stopAt = stopRound;
        model_inv(n, lat, tmo, stopRound);
        clear();
        issue(CMD_INV);
        finish_txn(tag);
        stopAt = 0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int n, kind, tmo, nr, st;
        Reset = 1'b1;
        r_ExecHostCmd = 4'd0;
        r_NumRounds = 8'd0;
        r_TmoLimit = 16'd0;
        fLat = -1; iLat = -1; rLat = -1; aLat = -1;
        stopAt = 0;
        eCnt = 0;
        clear();

        repeat (2) @(posedge Clk);
        #1;
        check("reset_outputs", outs, 0);
        check("reset_state", SeqState, S_IDLE);
        Reset = 1'b0;
        step();

        // three inventory rounds, End 10 cycles after each start
        r_NumRounds = 8'd3;
        r_TmoLimit = 16'd0;
        iLat = 10;
        model_inv(3, 10, 0, 0);
        clear();
        issue(CMD_INV);
        check("inv3_rst_host_next_cycle", s_RstHostCmd, 1);
        finish_txn("inv3");

        // endless inventory stopped during round 5
        run_inv("inv_stop5", 0, $urandom_range(2, 6), 0, 5);

        // ReqRN then access
        run_access("access_ok", $urandom_range(0, 5), $urandom_range(0, 5), 0);

        // watchdog in FILTER: expiry, then End on the limit cycle
        run_filter("filter_tmo", -1, 20);
        run_filter("filter_end_on_limit", 19, 20);
        run_filter("filter_end_after_limit", 20, 20);

        // purge in IDLE
        model_base();
        ePurge = 1;
        eStatus = 2'd1;
        clear();
        issue(CMD_PURGE);
        finish_txn("purge_idle");

        // purge while inventory runs is ignored (except for the clear request)
        r_NumRounds = 8'd2;
        r_TmoLimit = 16'd0;
        iLat = 3;
        model_inv(2, 3, 0, 0);
        eRst = 2;
        clear();
        issue(CMD_INV);
        step();
        issue(CMD_PURGE);
        check("purge_in_inv_busy", s_Busy, 1);
        finish_txn("purge_in_inv");

        // undefined command code
        clear();
        issue(4'hF);
        check("bad_cmd_rst_host", s_RstHostCmd, 0);
        repeat (3) step();
        check("bad_cmd_rst_count", nRst, 0);
        check("bad_cmd_path", path_q.size(), 1);
        check("bad_cmd_state", SeqState, S_IDLE);

        // stop in IDLE does nothing but request the register clear
        clear();
        issue(CMD_STOP);
        repeat (3) step();
        check("stop_idle_done", nDone, 0);
        check("stop_idle_path", path_q.size(), 1);
        check("stop_idle_rst", nRst, 1);

        // randomized transactions
        for (int it = 0; it < 10; it++) begin
            kind = $urandom_range(0, 2);
            tmo = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 8) : 0;
            if (kind == 0) begin
                run_filter($sformatf("rnd%0d_filter", it), $urandom_range(0, 6), tmo);
            end else if (kind == 1) begin
                run_access($sformatf("rnd%0d_access", it), $urandom_range(0, 6),
                           $urandom_range(0, 6), tmo);
            end else begin
                nr = $urandom_range(0, 4);
                if (nr == 0) st = $urandom_range(1, 4);
                else st = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 4) : 0;
                run_inv($sformatf("rnd%0d_inv", it), nr, $urandom_range(0, 6), tmo, st);
            end
        end

        // asynchronous reset in the middle of ACCESS
        r_TmoLimit = 16'd0;
        rLat = 2;
        aLat = -1;
        clear();
        issue(CMD_ACCESS);
        n = 0;
        while ((SeqState != S_ACCESS) && (n < 50)) begin
            step();
            n++;
        end
        check("rst_mid_reach_access", SeqState, S_ACCESS);
        #2 Reset = 1'b1;
        #1;
        check("rst_mid_async_outputs", outs, 0);
        check("rst_mid_async_state", SeqState, S_IDLE);
        step();
        check("rst_mid_held_outputs", outs, 0);
        Reset = 1'b0;
        eCnt = 0;
        repeat (3) step();
        check("rst_mid_no_done", nDone, 0);
        check("rst_mid_idle", SeqState, S_IDLE);

        // sequencer still works after the reset
        run_filter("after_reset_filter", 2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
